pkg_frame_tx: RTL and testbench



---
 rtl/pkg_frame_defs.sv | 17 +
 rtl/pkg_frame_buf.sv | 23 ++
 rtl/pkg_frame_tx.sv | 160 ++++++++++++++++
 tb/tb_pkg_frame_tx.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkg_frame_defs.sv
// Shared definitions for the packet-store frame transmitter: FSM state
// encoding and the default framing constants.
package pkg_frame_defs;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    HDR,
    LEN,
    PAYLOAD,
    CSUM
  } state_t;

  localparam logic [7:0] SOF_BYTE_DEFAULT = 8'hA5;
  localparam int         CSUM_WIDTH       = 8;

endpackage

// File: rtl/pkg_frame_buf.sv
// Burst buffer: register-based simple dual-port RAM with synchronous write
// and asynchronous read, so the next payload word is ready in the same cycle.
module pkg_frame_buf #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pkg_frame_tx.sv
// Captures a non-stallable burst from the packet store and re-emits it as a
// SOF / LEN / payload / checksum frame over a valid/ready link.
module pkg_frame_tx
  import pkg_frame_defs::*;
#(
  parameter int                    DATA_WIDTH = CSUM_WIDTH,
  parameter int                    ADDR_WIDTH = 7,
  parameter logic [DATA_WIDTH-1:0] SOF_BYTE   = DATA_WIDTH'(SOF_BYTE_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pkg_num_vld,
  input  logic [ADDR_WIDTH-1:0] pkg_num,
  input  logic [DATA_WIDTH-1:0] pkg_data,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  tx_sof,
  output logic                  tx_eof,
  output logic                  busy,
  output logic                  err_drop
);

  state_t                state;
  logic                  vld_q;
  logic [ADDR_WIDTH-1:0] n_q;
  logic [ADDR_WIDTH-1:0] wr_cnt;
  logic [ADDR_WIDTH-1:0] rd_cnt;
  logic [DATA_WIDTH-1:0] csum_acc;

  logic                  start;
  logic                  hs;
  logic                  buf_we;
  logic [ADDR_WIDTH-1:0] buf_waddr;
  logic [DATA_WIDTH-1:0] buf_rdata;

  assign start = pkg_num_vld & ~vld_q;
  assign hs    = tx_valid & tx_ready;

  // Word 0 lands at the start edge itself, so the write port is open in IDLE too.
  assign buf_we    = ((state == IDLE) && start && (pkg_num != '0)) || (state == CAPTURE);
  assign buf_waddr = (state == CAPTURE) ? wr_cnt : '0;

  pkg_frame_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_buf (
    .clk     (clk),
    .wr_en   (buf_we),
    .wr_addr (buf_waddr),
    .wr_data (pkg_data),
    .rd_addr (rd_cnt),
    .rd_data (buf_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      vld_q    <= 1'b0;
      n_q      <= '0;
      wr_cnt   <= '0;
      rd_cnt   <= '0;
      csum_acc <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      tx_sof   <= 1'b0;
      tx_eof   <= 1'b0;
      busy     <= 1'b0;
      err_drop <= 1'b0;
    end else begin
      vld_q    <= pkg_num_vld;
      err_drop <= start && (state != IDLE);

      case (state)
        IDLE: begin
          if (start) begin
            if (pkg_num == '0) begin
              err_drop <= 1'b1;
            end else begin
              n_q      <= pkg_num;
              wr_cnt   <= ADDR_WIDTH'(1);
              rd_cnt   <= '0;
              csum_acc <= DATA_WIDTH'(pkg_num) + pkg_data;
              busy     <= 1'b1;
              if (pkg_num == ADDR_WIDTH'(1)) begin
                state    <= HDR;
                tx_valid <= 1'b1;
                tx_data  <= SOF_BYTE;
                tx_sof   <= 1'b1;
              end else begin
                state <= CAPTURE;
              end
            end
          end
        end

        // The store cannot stall, so capture runs for exactly N words regardless of the link.
        CAPTURE: begin
          wr_cnt   <= wr_cnt + 1'b1;
          csum_acc <= csum_acc + pkg_data;
          if (wr_cnt == n_q - 1'b1) begin
            state    <= HDR;
            tx_valid <= 1'b1;
            tx_data  <= SOF_BYTE;
            tx_sof   <= 1'b1;
          end
        end

        HDR: begin
          if (hs) begin
            state   <= LEN;
            tx_sof  <= 1'b0;
            tx_data <= DATA_WIDTH'(n_q);
          end
        end

        LEN: begin
          if (hs) begin
            state   <= PAYLOAD;
            tx_data <= buf_rdata;
            rd_cnt  <= rd_cnt + 1'b1;
          end
        end

        // rd_cnt always points one word past the beat on the wire.
        PAYLOAD: begin
          if (hs) begin
            if (rd_cnt == n_q) begin
              state   <= CSUM;
              tx_data <= -csum_acc;
              tx_eof  <= 1'b1;
            end else begin
              tx_data <= buf_rdata;
              rd_cnt  <= rd_cnt + 1'b1;
            end
          end
        end

        CSUM: begin
          if (hs) begin
            state    <= IDLE;
            tx_valid <= 1'b0;
            tx_eof   <= 1'b0;
            tx_data  <= '0;
            busy     <= 1'b0;
          end
        end

        default: begin
          state    <= IDLE;
          tx_valid <= 1'b0;
          tx_sof   <= 1'b0;
          tx_eof   <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pkg_frame_tx.sv
// Scoreboard bench for pkg_frame_tx: expected beats are queued when a burst is
// driven and checked against every valid beat the DUT presents.
module tb_pkg_frame_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       pkg_num_vld = 1'b0;
  logic [6:0] pkg_num = '0;
  logic [7:0] pkg_data = '0;
  logic       tx_ready = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_sof;
  logic       tx_eof;
  logic       busy;
  logic       err_drop;

  int         tests = 0;
  int         fails = 0;
  logic [9:0] exp_q[$];
  logic [7:0] burst[$];
  logic       saw_valid_in_capture;

  pkg_frame_tx dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pkg_num_vld (pkg_num_vld),
    .pkg_num     (pkg_num),
    .pkg_data    (pkg_data),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_sof      (tx_sof),
    .tx_eof      (tx_eof),
    .busy        (busy),
    .err_drop    (err_drop)
  );

  always #5 clk = ~clk;

  // Queues the expected frame for the words in burst, then streams them one per clock.
  task automatic drive_burst();
    logic [7:0] sum;
    int         n;
    n   = burst.size();
    sum = 8'(n);
    exp_q.push_back({1'b1, 1'b0, 8'hA5});
    exp_q.push_back({2'b00, 8'(n)});
    foreach (burst[k]) begin
      exp_q.push_back({2'b00, burst[k]});
      sum = sum + burst[k];
    end
    exp_q.push_back({2'b01, ~sum + 8'd1});
    saw_valid_in_capture = 1'b0;
    pkg_num     = 7'(n);
    pkg_num_vld = 1'b1;
    for (int k = 0; k < n; k++) begin
      pkg_data = burst[k];
      @(negedge clk);
      if (tx_valid) saw_valid_in_capture = 1'b1;
      @(posedge clk);
      #1;
    end
    pkg_num_vld = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({tx_valid, tx_sof, tx_eof, busy, err_drop, tx_data} !== 13'b0) begin
      fails++;
      $display("[TB] FAIL reset_outputs: got v=%b s=%b e=%b b=%b d=%b data=%h, want all 0",
               tx_valid, tx_sof, tx_eof, busy, err_drop, tx_data);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({tx_valid, busy, err_drop} !== 3'b000) begin
      fails++;
      $display("[TB] FAIL idle_after_reset: got v=%b b=%b d=%b, want 000", tx_valid, busy, err_drop);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int beats = 0;
    bit done = 0;
    burst = '{8'h11, 8'h22, 8'h33, 8'h44};
    exp_q.delete();
    tx_ready = 1'b1;
    drive_burst();
    tests++;
    if (saw_valid_in_capture !== 1'b0) begin
      fails++;
      $display("[TB] FAIL basic_valid_early: tx_valid high during capture, want low");
    end
    tests++;
    if ({tx_valid, tx_sof, busy} !== 3'b111) begin
      fails++;
      $display("[TB] FAIL basic_sof_timing: got v=%b sof=%b busy=%b after E3, want 111", tx_valid, tx_sof, busy);
    end
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      tx_ready = 1'b1;
      @(negedge clk);
      if (tx_valid) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("[TB] FAIL basic_extra_beat: got data=%h, want no beat", tx_data);
          done = 1;
        end else begin
          if ({tx_sof, tx_eof, tx_data} !== exp_q[0]) begin
            fails++;
            $display("[TB] FAIL basic_beat%0d: got sof=%b eof=%b data=%h, want %b", beats, tx_sof, tx_eof, tx_data, exp_q[0]);
          end
          void'(exp_q.pop_front());
          beats++;
          if (exp_q.size() == 0) done = 1;
        end
      end
      @(posedge clk);
      #1;
    end
    tests++;
    if (beats !== 7) begin
      fails++;
      $display("[TB] FAIL basic_beat_count: got %0d, want 7", beats);
    end
    tests++;
    if ({tx_valid, busy} !== 2'b00) begin
      fails++;
      $display("[TB] FAIL basic_end_idle: got v=%b busy=%b after last beat, want 00", tx_valid, busy);
    end
  endtask

  task automatic test_stall();
    int beats = 0;
    bit done = 0;
    burst = '{8'h11, 8'h22, 8'h33, 8'h44};
    exp_q.delete();
    tx_ready = 1'b1;
    drive_burst();
    // Every valid cycle, stalled or not, must show the head of the scoreboard.
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      tx_ready = (cyc % 3 == 0);
      @(negedge clk);
      if (tx_valid) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("[TB] FAIL stall_extra_beat: got data=%h, want no beat", tx_data);
          done = 1;
        end else begin
          if ({tx_sof, tx_eof, tx_data} !== exp_q[0]) begin
            fails++;
            $display("[TB] FAIL stall_beat%0d cyc%0d: got sof=%b eof=%b data=%h, want %b",
                     beats, cyc, tx_sof, tx_eof, tx_data, exp_q[0]);
          end
          if (tx_ready) begin
            void'(exp_q.pop_front());
            beats++;
            if (exp_q.size() == 0) done = 1;
          end
        end
      end
      @(posedge clk);
      #1;
    end
    tx_ready = 1'b1;
    tests++;
    if (beats !== 7) begin
      fails++;
      $display("[TB] FAIL stall_beat_count: got %0d, want 7", beats);
    end
    tests++;
    if ({tx_valid, busy} !== 2'b00) begin
      fails++;
      $display("[TB] FAIL stall_end_idle: got v=%b busy=%b, want 00", tx_valid, busy);
    end
  endtask

  task automatic test_zero();
    bit active = 0;
    pkg_num     = 7'd0;
    pkg_num_vld = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (err_drop !== 1'b1) begin
      fails++;
      $display("[TB] FAIL zero_drop_pulse: got err_drop=%b, want 1", err_drop);
    end
    @(posedge clk);
    #1;
    tests++;
    if (err_drop !== 1'b0) begin
      fails++;
      $display("[TB] FAIL zero_drop_width: got err_drop=%b second cycle, want 0", err_drop);
    end
    pkg_num_vld = 1'b0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      if (tx_valid || busy) active = 1;
    end
    tests++;
    if (active !== 1'b0) begin
      fails++;
      $display("[TB] FAIL zero_no_frame: got tx_valid/busy activity=%b, want 0", active);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_busy_drop();
    int beats = 0;
    int drops = 0;
    bit done = 0;
    bit raised = 0;
    bit active = 0;
    burst = '{8'h01, 8'h02, 8'h03, 8'h04};
    exp_q.delete();
    tx_ready = 1'b1;
    drive_burst();
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      if (beats == 3 && !raised) begin
        pkg_num     = 7'd5;
        pkg_num_vld = 1'b1;
        raised      = 1;
      end
      @(negedge clk);
      if (err_drop) drops++;
      if (tx_valid) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("[TB] FAIL busy_extra_beat: got data=%h, want no beat", tx_data);
          done = 1;
        end else begin
          if ({tx_sof, tx_eof, tx_data} !== exp_q[0]) begin
            fails++;
            $display("[TB] FAIL busy_beat%0d: got sof=%b eof=%b data=%h, want %b", beats, tx_sof, tx_eof, tx_data, exp_q[0]);
          end
          void'(exp_q.pop_front());
          beats++;
          if (exp_q.size() == 0) done = 1;
        end
      end
      @(posedge clk);
      #1;
    end
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (err_drop) drops++;
      if (tx_valid || busy) active = 1;
    end
    pkg_num_vld = 1'b0;
    tests++;
    if (beats !== 7) begin
      fails++;
      $display("[TB] FAIL busy_beat_count: got %0d, want 7", beats);
    end
    tests++;
    if (drops !== 1) begin
      fails++;
      $display("[TB] FAIL busy_drop_pulses: got %0d err_drop cycles, want 1", drops);
    end
    tests++;
    if (active !== 1'b0) begin
      fails++;
      $display("[TB] FAIL busy_no_second_frame: got activity=%b, want 0", active);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_max();
    int beats = 0;
    bit done = 0;
    burst.delete();
    for (int k = 0; k < 127; k++) burst.push_back(8'(k + 1));
    exp_q.delete();
    tx_ready = 1'b1;
    drive_burst();
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      tx_ready = 1'b1;
      @(negedge clk);
      if (tx_valid) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("[TB] FAIL max_extra_beat: got data=%h, want no beat", tx_data);
          done = 1;
        end else begin
          if ({tx_sof, tx_eof, tx_data} !== exp_q[0]) begin
            fails++;
            $display("[TB] FAIL max_beat%0d: got sof=%b eof=%b data=%h, want %b", beats, tx_sof, tx_eof, tx_data, exp_q[0]);
          end
          void'(exp_q.pop_front());
          beats++;
          if (exp_q.size() == 0) done = 1;
        end
      end
      @(posedge clk);
      #1;
    end
    tests++;
    if (beats !== 130) begin
      fails++;
      $display("[TB] FAIL max_beat_count: got %0d, want 130", beats);
    end
  endtask

  task automatic test_reset_mid();
    int beats = 0;
    bit done = 0;
    burst = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    exp_q.delete();
    tx_ready = 1'b1;
    drive_burst();
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      if (beats == 4) begin
        rst_n = 1'b0;
        #1;
        tests++;
        if ({tx_valid, busy, tx_sof, tx_eof} !== 4'b0000) begin
          fails++;
          $display("[TB] FAIL reset_mid_async: got v=%b busy=%b sof=%b eof=%b, want 0000", tx_valid, busy, tx_sof, tx_eof);
        end
        done = 1;
      end else begin
        @(negedge clk);
        if (tx_valid && exp_q.size() != 0) begin
          void'(exp_q.pop_front());
          beats++;
        end
        @(posedge clk);
        #1;
      end
    end
    tests++;
    if (done !== 1'b1) begin
      fails++;
      $display("[TB] FAIL reset_mid_timeout: reached %0d beats, want 4 before reset", beats);
    end
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    burst = '{8'hAA, 8'h55};
    drive_burst();
    tests++;
    if (exp_q[4] !== {2'b01, 8'hFF}) begin
      fails++;
      $display("[TB] FAIL reset_mid_model_csum: got %b, want 01_11111111", exp_q[4]);
    end
    beats = 0;
    done  = 0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      tx_ready = 1'b1;
      @(negedge clk);
      if (tx_valid) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("[TB] FAIL post_reset_extra_beat: got data=%h, want no beat", tx_data);
          done = 1;
        end else begin
          if ({tx_sof, tx_eof, tx_data} !== exp_q[0]) begin
            fails++;
            $display("[TB] FAIL post_reset_beat%0d: got sof=%b eof=%b data=%h, want %b", beats, tx_sof, tx_eof, tx_data, exp_q[0]);
          end
          void'(exp_q.pop_front());
          beats++;
          if (exp_q.size() == 0) done = 1;
        end
      end
      @(posedge clk);
      #1;
    end
    tests++;
    if (beats !== 5) begin
      fails++;
      $display("[TB] FAIL post_reset_beat_count: got %0d, want 5", beats);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_zero();
    test_busy_drop();
    test_max();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
